mantissa_mult_seq: RTL and testbench
====================================

Name: mantissa_mult_seq

Overview:
- Iterative, handshaked mantissa multiplier for the floating-point multiply datapath.
- Forms the full-width product of two significands with a per-operand hidden bit.
- Hidden bit is 1 for normal operands and 0 for subnormals, so the FP multiply top can handle denormals.
- Trades area for latency with a shift-and-add core that retires BITS_PER_CYCLE multiplier bits per clock; product and MSB feed the normalise/exponent-adjust stage.

Parameters:
- MAN_W, 23, stored mantissa width (23 single, 52 double); significand width N = MAN_W+1.
- BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle. Must divide N; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- man_a  input  MAN_W  mantissa A, fraction bits only.
- man_b  input  MAN_W  mantissa B, fraction bits only.
- sub_a  input  1  1 = A subnormal, hidden bit 0.
- sub_b  input  1  1 = B subnormal, hidden bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- product  output  2*N  {~sub_a,man_a} * {~sub_b,man_b}, unsigned.
- msb_bit  output  1  product[2*N-1], normalisation indicator.
- zero  output  1  product == 0.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, in_ready=1, out_valid=0, product=0, msb_bit=0, zero=0, internal counter and accumulator cleared.
- Reset asserted mid-operation aborts the operation; no result is produced.
- ITER = N/BITS_PER_CYCLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready edge (E0), latch mcand={~sub_a,man_a} and mplier={~sub_b,man_b}, clear accumulator and counter, go to BUSY.
  - Operand inputs are don't-care after E0.
- BUSY:
  - in_ready=0.
  - Each edge adds mcand*(low BITS_PER_CYCLE bits of mplier), shifted by counter*BITS_PER_CYCLE, into the 2N-bit accumulator.
  - mplier shifts right by BITS_PER_CYCLE; counter increments.
  - On the edge retiring the last chunk (E_ITER), load product/msb_bit/zero from the final sum and go to DONE with out_valid=1.
  - Latency: out_valid is high ITER cycles after the accept edge (24 for defaults, 6 for BITS_PER_CYCLE=4).
- DONE:
  - out_valid=1; product/msb_bit/zero held stable while out_ready=0.
  - On out_valid&&out_ready edge: out_valid->0, go to IDLE.
  - in_ready is 0 in DONE, so no new accept on the same edge. Back-to-back throughput is one result per ITER+2 cycles.
- in_valid in BUSY/DONE is ignored: not accepted, not queued.
- Arithmetic:
  - Unsigned, exact, no rounding or truncation.
  - Accumulator is 2N bits wide and cannot overflow, since (2^N-1)^2 < 2^(2N).
  - msb_bit=1 only possible when both hidden bits are 1.
  - zero=1 iff either significand is all-zero, which requires the subnormal flag set and the mantissa 0.
- Outputs change only in the DONE-entry cycle; no combinational path from in_valid or out_ready to any output except through state.

Test Plan:
- Defaults, man_a=0, man_b=0, sub=0 -> after 24 cycles out_valid=1, product=0x4000_0000_0000, msb_bit=0, zero=0.
- man_a=man_b=0x7FFFFF, sub=0 -> product=0xFFFF_FE00_0001, msb_bit=1, zero=0.
- sub_a=1, man_a=0, man_b=0x123456 -> product=0, zero=1, msb_bit=0.
- sub_a=1, man_a=0x000001, sub_b=0, man_b=0 -> product=0x800000, zero=0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and product stable, in_ready=0, extra in_valid ignored. Release -> IDLE next cycle, in_ready=1.
- rst_n pulsed low at BUSY cycle 12 -> out_valid=0, in_ready=1 immediately, no spurious result afterward. BITS_PER_CYCLE=4 build, 0x7FFFFF² -> same product after 6 cycles.

Source files
------------

// File: rtl/mantissa_mult_seq.sv
// Iterative shift-and-add significand multiplier for the FP multiply datapath.
// Hidden bits come from the subnormal flags; retires BITS_PER_CYCLE multiplier bits per clock.
module mantissa_mult_seq #(
  parameter int MAN_W          = 23,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W-1:0]       man_a,
  input  logic [MAN_W-1:0]       man_b,
  input  logic                   sub_a,
  input  logic                   sub_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*(MAN_W+1)-1:0] product,
  output logic                   msb_bit,
  output logic                   zero
);

  localparam int N    = MAN_W + 1;
  localparam int PW   = 2 * N;
  localparam int PPW  = N + BITS_PER_CYCLE;
  localparam int ITER = N / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  generate
    if ((BITS_PER_CYCLE < 1) || ((N % BITS_PER_CYCLE) != 0)) begin : g_bad_bpc
      $error("mantissa_mult_seq: BITS_PER_CYCLE must divide MAN_W+1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_mcand;
  logic [N-1:0]    r_mplier;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_product;
  logic            r_msb;
  logic            r_zero;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [PPW-1:0]  w_pp;
  logic [31:0]     w_shamt;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_sum;

  // One partial product per cycle, weighted by the chunk position already retired.
  assign w_pp     = PPW'(r_mcand) * PPW'(r_mplier[BITS_PER_CYCLE-1:0]);
  assign w_shamt  = 32'(r_cnt) * BITS_PER_CYCLE;
  assign w_addend = PW'(w_pp) << w_shamt;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_msb       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= {~sub_a, man_a};
            r_mplier   <= {~sub_b, man_b};
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_sum;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_product   <= w_sum;
            r_msb       <= w_sum[PW-1];
            r_zero      <= (w_sum == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Ready is reasserted only after the result leaves, so no accept overlaps DONE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign msb_bit   = r_msb;
  assign zero      = r_zero;

endmodule

// File: tb/tb_mantissa_mult_seq.sv
// Scoreboard bench for mantissa_mult_seq: default build and BITS_PER_CYCLE=4 build side by side.
module tb_mantissa_mult_seq;

  localparam int MAN_W = 23;
  localparam int N     = MAN_W + 1;
  localparam int PW    = 2 * N;
  localparam int ITER1 = N / 1;
  localparam int ITER4 = N / 4;

  typedef struct {
    logic [PW-1:0] prod;
    logic          msb;
    logic          zero;
    int            acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [MAN_W-1:0] man_a = '0;
  logic [MAN_W-1:0] man_b = '0;
  logic             sub_a = 1'b0;
  logic             sub_b = 1'b0;

  logic             in_ready1, out_valid1, msb1, zero1;
  logic [PW-1:0]    prod1;
  logic             in_ready4, out_valid4, msb4, zero4;
  logic [PW-1:0]    prod4;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  exp_t q[2][$];
  bit   seen[2];

  mantissa_mult_seq #(.MAN_W(MAN_W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .man_a(man_a), .man_b(man_b), .sub_a(sub_a), .sub_b(sub_b),
    .out_valid(out_valid1), .out_ready(out_ready), .product(prod1),
    .msb_bit(msb1), .zero(zero1)
  );

  mantissa_mult_seq #(.MAN_W(MAN_W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .man_a(man_a), .man_b(man_b), .sub_a(sub_a), .sub_b(sub_b),
    .out_valid(out_valid4), .out_ready(out_ready), .product(prod4),
    .msb_bit(msb4), .zero(zero4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: plain integer product of the two significands.
  function automatic exp_t model(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b,
                                 input logic sa, input logic sb);
    longint unsigned sig_a, sig_b, p;
    exp_t e;
    sig_a = (sa ? 64'd0 : (64'd1 << MAN_W)) + 64'(a);
    sig_b = (sb ? 64'd0 : (64'd1 << MAN_W)) + 64'(b);
    p = sig_a * sig_b;
    e.prod    = PW'(p);
    e.msb     = (p >= (64'd1 << (PW - 1)));
    e.zero    = (p == 64'd0);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic mon(input int d, input logic ov, input logic ir, input logic [PW-1:0] p,
                     input logic m, input logic z);
    string tag;
    tag = (d == 0) ? "bpc1" : "bpc4";
    if (rst_n !== 1'b1 || ov !== 1'b1) return;
    if (q[d].size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s spurious result: out_valid=1 product=0x%0h, expected no result", tag, p);
      return;
    end
    if (!seen[d]) begin
      chk({tag, " latency"}, 64'(cyc - q[d][0].acc_cyc), 64'((d == 0) ? ITER1 : ITER4));
      seen[d] = 1'b1;
    end
    chk({tag, " product"}, 64'(p), 64'(q[d][0].prod));
    chk({tag, " msb_bit"}, 64'(m), 64'(q[d][0].msb));
    chk({tag, " zero"}, 64'(z), 64'(q[d][0].zero));
    chk({tag, " in_ready in DONE"}, 64'(ir), 64'd0);
    if (out_ready) begin
      void'(q[d].pop_front());
      seen[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, out_valid1, in_ready1, prod1, msb1, zero1);
    mon(1, out_valid4, in_ready4, prod4, msb4, zero4);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b,
                       input logic sa, input logic sb);
    exp_t e;
    int   w;
    w = 0;
    while (!(in_ready1 && in_ready4)) begin
      step();
      w++;
      if (w > 300) begin
        total++;
        bad++;
        $display("FAIL issue timeout: in_ready=%0b/%0b, expected 1/1", in_ready1, in_ready4);
        $fatal(1, "in_ready stuck");
      end
    end
    man_a = a; man_b = b; sub_a = sa; sub_b = sb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    e = model(a, b, sa, sb);
    e.acc_cyc = cyc;
    q[0].push_back(e);
    q[1].push_back(e);
  endtask

  task automatic drain(input int maxc);
    int w;
    w = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && w < maxc) begin
      step();
      w++;
    end
    chk("drain bpc1 pending", 64'(q[0].size()), 64'd0);
    chk("drain bpc4 pending", 64'(q[1].size()), 64'd0);
  endtask

  initial begin
    exp_t             h;
    int               w;
    logic [MAN_W-1:0] ra, rb;
    logic             rsa, rsb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready1), 64'd1);
    chk("reset out_valid", 64'(out_valid1), 64'd0);
    chk("reset product", 64'(prod1), 64'd0);
    chk("reset msb_bit", 64'(msb1), 64'd0);
    chk("reset zero", 64'(zero1), 64'd0);
    chk("reset bpc4 out_valid", 64'(out_valid4), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post-reset in_ready", 64'(in_ready1), 64'd1);

    issue(23'h000000, 23'h000000, 1'b0, 1'b0);
    issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
    issue(23'h000000, 23'h123456, 1'b1, 1'b0);
    issue(23'h000001, 23'h000000, 1'b1, 1'b0);
    issue(23'h000000, 23'h000000, 1'b1, 1'b1);
    issue(23'h400000, 23'h7FFFFF, 1'b1, 1'b1);
    drain(200);

    // Backpressure in DONE with a competing in_valid.
    out_ready = 1'b0;
    h = model(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
    issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
    w = 0;
    while (!out_valid1 && w < 100) begin
      step();
      w++;
    end
    chk("hold reached DONE", 64'(out_valid1), 64'd1);
    man_a = 23'h000005; man_b = 23'h000003;
    in_valid = 1'b1;
    repeat (10) step();
    chk("hold out_valid", 64'(out_valid1), 64'd1);
    chk("hold product", 64'(prod1), 64'(h.prod));
    chk("hold in_ready", 64'(in_ready1), 64'd0);
    chk("hold bpc4 out_valid", 64'(out_valid4), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release out_valid", 64'(out_valid1), 64'd0);
    chk("release in_ready", 64'(in_ready1), 64'd1);
    chk("release bpc4 in_ready", 64'(in_ready4), 64'd1);
    repeat (30) step();
    chk("hold extra accepts", 64'(q[0].size()), 64'd0);

    // Reset in the middle of BUSY.
    issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q[0].delete();
    q[1].delete();
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    chk("midreset out_valid", 64'(out_valid1), 64'd0);
    chk("midreset in_ready", 64'(in_ready1), 64'd1);
    chk("midreset product", 64'(prod1), 64'd0);
    chk("midreset bpc4 in_ready", 64'(in_ready4), 64'd1);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("midreset in_ready after", 64'(in_ready1), 64'd1);

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      ra  = ($urandom_range(0, 7) == 0) ? '0 : MAN_W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : MAN_W'($urandom);
      rsa = ($urandom_range(0, 3) == 0);
      rsb = ($urandom_range(0, 3) == 0);
      issue(ra, rb, rsa, rsb);
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    drain(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
